// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the core load/store path (port C)
// and a DMA/debug loader (port D). Requests are arbitrated round-robin in IDLE.
// Each access then steps through a fixed sequence:
//   IDLE -> ISSUE -> (write) IDLE
//   IDLE -> ISSUE -> WAIT x MEM_LAT -> RESP -> IDLE   (read)
//
// Handshake: a requester holds req together with we/addr/wdata until it sees
// a one-cycle gnt pulse. In the cycle after gnt it either drops req or
// presents a new access. A req that is still high when the arbiter is back in
// IDLE counts as a new access. Reads complete with a one-cycle rvalid pulse.
// rdata then holds its value until that port's next read completes.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata   core request (in)
//   c_gnt/c_rvalid/c_rdata      core grant, read-valid pulse, read data (out)
//   d_*                 same set of signals for the DMA port
//   mem_wr/mem_rd/mem_addr/mem_wr_data   memory strobes; nonzero only in ISSUE
//   mem_rd_data         memory read data, valid MEM_LAT cycles after mem_rd
//   busy                high in every state except IDLE
//   dbg_state           current FSM state, for observation
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Port identifiers used for winner and last_winner.
    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [2:0] LAT_C = 3'(MEM_LAT);

    state_e              state_q, state_d;
    logic                winner_q, winner_d;
    logic                last_winner_q, last_winner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic                pick_c;
    logic                in_issue;
    logic                in_resp;

    // Next-state and datapath latches.
    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        last_winner_d = last_winner_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        c_rdata_d     = c_rdata_q;
        d_rdata_d     = d_rdata_q;
        // The core wins when it asks alone, or on a tie when D won last time.
        pick_c        = c_req && (!d_req || (last_winner_q == PORT_D));

        unique case (state_q)
            ST_IDLE: begin
                if (pick_c) begin
                    winner_d      = PORT_C;
                    last_winner_d = PORT_C;
                    we_d          = c_we;
                    addr_d        = c_addr;
                    wdata_d       = c_wdata;
                    state_d       = ST_ISSUE;
                end else if (d_req) begin
                    winner_d      = PORT_D;
                    last_winner_d = PORT_D;
                    we_d          = d_we;
                    addr_d        = d_addr;
                    wdata_d       = d_wdata;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 3'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAT_C) begin
                    // Only the winner's read-data register is written.
                    if (winner_q == PORT_C) begin
                        c_rdata_d = mem_rd_data;
                    end else begin
                        d_rdata_d = mem_rd_data;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            winner_q      <= PORT_C;
            last_winner_q <= PORT_D;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= 3'd0;
            c_rdata_q     <= '0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            last_winner_q <= last_winner_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            c_rdata_q     <= c_rdata_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    // All outputs are decoded from registered state only. Asserting reset
    // therefore forces them to 0 at once, and an aborted access cannot
    // produce a late gnt or rvalid.
    assign in_issue    = (state_q == ST_ISSUE);
    assign in_resp     = (state_q == ST_RESP);

    assign mem_wr      = in_issue &  we_q;
    assign mem_rd      = in_issue & ~we_q;
    assign mem_addr    = in_issue ? addr_q  : '0;
    assign mem_wr_data = in_issue ? wdata_q : '0;

    assign c_gnt       = in_issue & (winner_q == PORT_C);
    assign d_gnt       = in_issue & (winner_q == PORT_D);
    assign c_rvalid    = in_resp  & (winner_q == PORT_C);
    assign d_rvalid    = in_resp  & (winner_q == PORT_D);

    assign c_rdata     = c_rdata_q;
    assign d_rdata     = d_rdata_q;

    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. Two instances share clk and reset:
//   dut_a  MEM_LAT=1
//   dut_b  MEM_LAT=3
// Each instance sees a small memory model. On every mem_rd the model returns
// rom[addr] exactly MEM_LAT cycles later, and a poison word in every other
// cycle.
//
// Cycle convention: inputs are driven and outputs are checked 1 ns after a
// rising edge. Cycle 0 is the first cycle in which the request is visible in
// IDLE.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    // ---------------- instance A (MEM_LAT=1) ----------------
    logic          a_c_req = 1'b0, a_c_we = 1'b0, a_d_req = 1'b0, a_d_we = 1'b0;
    logic [AW-1:0] a_c_addr = '0, a_d_addr = '0;
    logic [DW-1:0] a_c_wdata = '0, a_d_wdata = '0;
    logic          a_c_gnt, a_c_rvalid, a_d_gnt, a_d_rvalid;
    logic          a_mem_wr, a_mem_rd, a_busy;
    logic [DW-1:0] a_c_rdata, a_d_rdata, a_mem_wr_data;
    logic [DW-1:0] a_mem_rd_data = '0;
    logic [AW-1:0] a_mem_addr;
    logic [1:0]    a_dbg_state;

    // ---------------- instance B (MEM_LAT=3) ----------------
    logic          b_c_req = 1'b0, b_c_we = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
    logic [AW-1:0] b_c_addr = '0, b_d_addr = '0;
    logic [DW-1:0] b_c_wdata = '0, b_d_wdata = '0;
    logic          b_c_gnt, b_c_rvalid, b_d_gnt, b_d_rvalid;
    logic          b_mem_wr, b_mem_rd, b_busy;
    logic [DW-1:0] b_c_rdata, b_d_rdata, b_mem_wr_data;
    logic [DW-1:0] b_mem_rd_data;
    logic [AW-1:0] b_mem_addr;
    logic [1:0]    b_dbg_state;

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .c_req(a_c_req), .c_we(a_c_we), .c_addr(a_c_addr), .c_wdata(a_c_wdata),
        .c_gnt(a_c_gnt), .c_rvalid(a_c_rvalid), .c_rdata(a_c_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_wr(a_mem_wr), .mem_rd(a_mem_rd), .mem_addr(a_mem_addr),
        .mem_wr_data(a_mem_wr_data), .mem_rd_data(a_mem_rd_data),
        .busy(a_busy), .dbg_state(a_dbg_state)
    );

    dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
        .c_gnt(b_c_gnt), .c_rvalid(b_c_rvalid), .c_rdata(b_c_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_wr(b_mem_wr), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr),
        .mem_wr_data(b_mem_wr_data), .mem_rd_data(b_mem_rd_data),
        .busy(b_busy), .dbg_state(b_dbg_state)
    );

    // ---------------- memory models ----------------
    logic [DW-1:0] rom_a [0:511];
    logic [DW-1:0] rom_b [0:511];
    logic [DW-1:0] b_p1 = '0, b_p2 = '0, b_p3 = '0;

    always @(posedge clk) begin
        a_mem_rd_data <= a_mem_rd ? rom_a[a_mem_addr] : POISON;
        b_p1          <= b_mem_rd ? rom_b[b_mem_addr] : POISON;
        b_p2          <= b_p1;
        b_p3          <= b_p2;
    end
    assign b_mem_rd_data = b_p3;

    // ---------------- scoreboard counters / checker ----------------
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Control bits {c_gnt, c_rvalid, d_gnt, d_rvalid, mem_wr, mem_rd, busy}.
    function automatic logic [6:0] ctl_a();
        return {a_c_gnt, a_c_rvalid, a_d_gnt, a_d_rvalid, a_mem_wr, a_mem_rd, a_busy};
    endfunction

    function automatic logic [6:0] ctl_b();
        return {b_c_gnt, b_c_rvalid, b_d_gnt, b_d_rvalid, b_mem_wr, b_mem_rd, b_busy};
    endfunction

    // Advance one clock and settle 1 ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    localparam logic [6:0] CTL_IDLE   = 7'b000_0000;
    localparam logic [6:0] CTL_C_RD   = 7'b100_0011;
    localparam logic [6:0] CTL_C_WR   = 7'b100_0101;
    localparam logic [6:0] CTL_D_WR   = 7'b001_0101;
    localparam logic [6:0] CTL_WAIT   = 7'b000_0001;
    localparam logic [6:0] CTL_C_RESP = 7'b010_0001;

    initial begin
        for (int i = 0; i < 512; i++) begin
            rom_a[i] = 32'hBAD0_0000 | i;
            rom_b[i] = 32'hBAD1_0000 | i;
        end
        rom_a[9'h010] = 32'hDEAD_BEEF;
        rom_b[9'h020] = 32'hCAFE_F00D;
        rom_b[9'h021] = 32'h1357_9BDF;

        // ---------------- reset state ----------------
        #1;
        check("rst ctl a", 32'(ctl_a()), 32'(CTL_IDLE));
        check("rst ctl b", 32'(ctl_b()), 32'(CTL_IDLE));
        check("rst c_rdata a", a_c_rdata, 32'h0);
        check("rst d_rdata a", a_d_rdata, 32'h0);
        check("rst mem_addr a", 32'(a_mem_addr), 32'h0);
        check("rst mem_wr_data a", a_mem_wr_data, 32'h0);
        step();
        step();
        reset = 1'b1;

        // ---------------- T1: core read, MEM_LAT=1 ----------------
        check("t1 c0 ctl", 32'(ctl_a()), 32'(CTL_IDLE));
        a_c_req = 1'b1; a_c_we = 1'b0; a_c_addr = 9'h010;
        step();
        check("t1 c1 ctl", 32'(ctl_a()), 32'(CTL_C_RD));
        check("t1 c1 mem_addr", 32'(a_mem_addr), 32'h010);
        a_c_req = 1'b0;
        step();
        check("t1 c2 ctl", 32'(ctl_a()), 32'(CTL_WAIT));
        step();
        check("t1 c3 ctl", 32'(ctl_a()), 32'(CTL_C_RESP));
        check("t1 c3 c_rdata", a_c_rdata, 32'hDEAD_BEEF);
        check("t1 c3 d_rdata", a_d_rdata, 32'h0);
        step();
        check("t1 c4 ctl", 32'(ctl_a()), 32'(CTL_IDLE));
        check("t1 c4 c_rdata held", a_c_rdata, 32'hDEAD_BEEF);

        // ---------------- T2: DMA write ----------------
        do_reset();
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 9'h1FF; a_d_wdata = 32'h1234_5678;
        step();
        check("t2 c1 ctl", 32'(ctl_a()), 32'(CTL_D_WR));
        check("t2 c1 mem_addr", 32'(a_mem_addr), 32'h1FF);
        check("t2 c1 mem_wr_data", a_mem_wr_data, 32'h1234_5678);
        a_d_req = 1'b0;
        step();
        check("t2 c2 ctl", 32'(ctl_a()), 32'(CTL_IDLE));
        check("t2 c2 mem_wr_data", a_mem_wr_data, 32'h0);
        step();
        check("t2 c3 ctl", 32'(ctl_a()), 32'(CTL_IDLE));
        check("t2 c3 d_rdata", a_d_rdata, 32'h0);

        // ---------------- T3: both held, writes, alternation ----------------
        do_reset();
        a_c_req = 1'b1; a_c_we = 1'b1; a_c_addr = 9'h001; a_c_wdata = 32'h0000_0011;
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 9'h002; a_d_wdata = 32'h0000_0022;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step();
            if (cyc == 1 || cyc == 5) begin
                check($sformatf("t3 c%0d ctl", cyc), 32'(ctl_a()), 32'(CTL_C_WR));
                check($sformatf("t3 c%0d addr", cyc), 32'(a_mem_addr), 32'h001);
                check($sformatf("t3 c%0d wdata", cyc), a_mem_wr_data, 32'h11);
            end else if (cyc == 3 || cyc == 7) begin
                check($sformatf("t3 c%0d ctl", cyc), 32'(ctl_a()), 32'(CTL_D_WR));
                check($sformatf("t3 c%0d addr", cyc), 32'(a_mem_addr), 32'h002);
                check($sformatf("t3 c%0d wdata", cyc), a_mem_wr_data, 32'h22);
            end else begin
                check($sformatf("t3 c%0d ctl", cyc), 32'(ctl_a()), 32'(CTL_IDLE));
            end
            if (cyc == 7) begin
                a_c_req = 1'b0;
                a_d_req = 1'b0;
            end
        end

        // ---------------- T4: MEM_LAT=3 read with pending DMA ----------------
        do_reset();
        b_c_req = 1'b1; b_c_we = 1'b0; b_c_addr = 9'h020;
        b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 9'h030; b_d_wdata = 32'h0000_55AA;
        step();
        check("t4 c1 ctl", 32'(ctl_b()), 32'(CTL_C_RD));
        check("t4 c1 mem_addr", 32'(b_mem_addr), 32'h020);
        b_c_req = 1'b0;
        for (int cyc = 2; cyc <= 4; cyc++) begin
            step();
            check($sformatf("t4 c%0d ctl", cyc), 32'(ctl_b()), 32'(CTL_WAIT));
        end
        step();
        check("t4 c5 ctl", 32'(ctl_b()), 32'(CTL_C_RESP));
        check("t4 c5 c_rdata", b_c_rdata, 32'hCAFE_F00D);
        step();
        check("t4 c6 ctl", 32'(ctl_b()), 32'(CTL_IDLE));
        step();
        check("t4 c7 ctl", 32'(ctl_b()), 32'(CTL_D_WR));
        check("t4 c7 mem_addr", 32'(b_mem_addr), 32'h030);
        check("t4 c7 mem_wr_data", b_mem_wr_data, 32'h0000_55AA);
        b_d_req = 1'b0;
        step();
        check("t4 c8 ctl", 32'(ctl_b()), 32'(CTL_IDLE));
        check("t4 c8 d_rdata", b_d_rdata, 32'h0);

        // ---------------- T5: reset during WAIT ----------------
        b_c_req = 1'b1; b_c_we = 1'b0; b_c_addr = 9'h020;
        step();
        check("t5 c1 ctl", 32'(ctl_b()), 32'(CTL_C_RD));
        b_c_req = 1'b0;
        step();
        check("t5 c2 ctl", 32'(ctl_b()), 32'(CTL_WAIT));
        reset = 1'b0;
        #1;
        check("t5 rst ctl", 32'(ctl_b()), 32'(CTL_IDLE));
        check("t5 rst c_rdata", b_c_rdata, 32'h0);
        check("t5 rst mem_addr", 32'(b_mem_addr), 32'h0);
        step();
        step();
        reset = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            step();
            check($sformatf("t5 post c%0d ctl", cyc), 32'(ctl_b()), 32'(CTL_IDLE));
        end
        b_c_req = 1'b1; b_c_we = 1'b0; b_c_addr = 9'h021;
        step();
        check("t5 fresh c1 ctl", 32'(ctl_b()), 32'(CTL_C_RD));
        check("t5 fresh c1 addr", 32'(b_mem_addr), 32'h021);
        b_c_req = 1'b0;
        step(); step(); step();
        check("t5 fresh c4 ctl", 32'(ctl_b()), 32'(CTL_WAIT));
        step();
        check("t5 fresh c5 ctl", 32'(ctl_b()), 32'(CTL_C_RESP));
        check("t5 fresh c5 c_rdata", b_c_rdata, 32'h1357_9BDF);

        // ---------------- T6: dropped vs held request ----------------
        do_reset();
        a_c_req = 1'b1; a_c_we = 1'b0; a_c_addr = 9'h005;
        #4;
        a_c_req = 1'b0;
        step();
        check("t6 dropped ctl", 32'(ctl_a()), 32'(CTL_IDLE));
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 9'h0AA; a_d_wdata = 32'h0000_00A5;
        step();
        check("t6 held ctl", 32'(ctl_a()), 32'(CTL_D_WR));
        check("t6 held addr", 32'(a_mem_addr), 32'h0AA);
        a_d_req = 1'b0;
        step();
        check("t6 after ctl", 32'(ctl_a()), 32'(CTL_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Two grants or two read-valids in the same cycle are never legal.
    always @(negedge clk) begin
        if (reset) begin
            if ((a_c_gnt && a_d_gnt) || (b_c_gnt && b_d_gnt))
                check("dual gnt", 32'd1, 32'd0);
            if ((a_c_rvalid && a_d_rvalid) || (b_c_rvalid && b_d_rvalid))
                check("dual rvalid", 32'd1, 32'd0);
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (port C) and a DMA/debug loader (port D).
- Arbitrates round-robin and sequences each access through a fixed-latency memory read pipeline.
- Drives the memory strobes (wr, rd, addr, wr_data) and returns read data with a one-cycle valid pulse.
- The core uses c_gnt and c_rvalid to stall its memory stage.

Parameters:
- DATA_W, 32, data width of requesters and memory.
- ADDR_W, 9, word address width of the data memory.
- MEM_LAT, 1, read latency in cycles from mem_rd asserted to mem_rd_data valid; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_req  in  1  core request; held with its fields until c_gnt.
- c_we  in  1  core access type: 1 = write, 0 = read.
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  one-cycle pulse: core access issued to memory.
- c_rvalid  out  1  one-cycle pulse: c_rdata holds read result.
- c_rdata  out  DATA_W  core read data; held until next core read completes.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata  same directions, widths and meanings for the DMA port.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wr_data  out  DATA_W  memory write data.
- mem_rd_data  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_rd cycle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; c_rdata=d_rdata=0; last_winner=D, so the core wins the first tie; wait counter=0.
- Any in-flight access is aborted: no gnt or rvalid is issued for it after reset releases.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample c_req and d_req.
  - Only one set: that port wins.
  - Both set: the port not equal to last_winner wins.
  - On a win: latch winner, we, addr and wdata; update last_winner; go to ISSUE.
  - Neither set: stay in IDLE.
  - Requests are only sampled in IDLE; a req dropped before sampling is ignored.
- ISSUE (exactly 1 cycle):
  - Drive mem_addr and mem_wr_data from the latches.
  - Assert mem_wr if we=1, otherwise mem_rd.
  - Pulse the winner's gnt.
  - Write: next state IDLE. Read: next state WAIT, counter=1.
- WAIT:
  - If counter==MEM_LAT: capture mem_rd_data into the winner's rdata register; go to RESP.
  - Otherwise: counter+1.
  - mem_wr, mem_rd, mem_addr, mem_wr_data all 0.
- RESP (1 cycle): pulse the winner's rvalid; go to IDLE.
- Outside ISSUE, all mem_* outputs are 0.
- Latency, with req seen in IDLE at cycle 0:
  - gnt and strobe at cycle 1.
  - Write complete; next arbitration at cycle 2.
  - Read: mem_rd_data sampled at end of cycle 1+MEM_LAT; rvalid at cycle 2+MEM_LAT; next arbitration at cycle 3+MEM_LAT.
- Requester rule: after gnt the requester must deassert req, or present a new access, in the cycle after gnt.
  - A req still high in IDLE is treated as a new access.
- Fairness: with both reqs held continuously, grants strictly alternate; no port waits more than one other access.
- The rdata of the non-winning port is never modified.
- At most one gnt and one rvalid are high in any cycle; c_gnt and d_gnt are never high together.
- Reset asserted during WAIT or RESP: rvalid must not pulse; the rdata registers clear to 0.

Test Plan:
- Core read, MEM_LAT=1: c_req=1, c_we=0, c_addr=0x010, memory returns 0xDEADBEEF → c_gnt and mem_rd at cycle 1 with mem_addr=0x010; c_rvalid at cycle 3 with c_rdata=0xDEADBEEF; d_* outputs stay 0.
- DMA write: d_req=1, d_we=1, d_addr=0x1FF, d_wdata=0x12345678 → d_gnt, mem_wr=1, mem_addr=0x1FF, mem_wr_data=0x12345678 all in cycle 1; busy low at cycle 2; no rvalid.
- Simultaneous requests held for 4 accesses, both writes → grant order C, D, C, D; each grant 2 cycles apart; never both gnt.
- MEM_LAT=3 read interleaved with a pending DMA request → d_gnt not before cycle 6; c_rvalid at cycle 5.
- Reset pulse (reset=0) during WAIT of a core read → all outputs 0 immediately; no c_rvalid after release; next c_req is served fresh with gnt at cycle 1.
- Request dropped in the same cycle arbitration would occur versus held one cycle → dropped req receives no gnt; held req receives gnt next cycle.
